// File: rtl/mips_cycle_sequencer_pkg.sv
// mips_cycle_sequencer_pkg
//   Shared definitions for the MIPS multi-cycle sequencer:
//   - state_e      : sequencer state encoding (value 7 is unused/illegal)
//   - inst_class_e : instruction class encoding as driven on inst_class
//   - LEN_*        : instruction lengths in cycles, including the DUMMY cycle
//   - helpers      : last working state / exit state / length per class
package mips_cycle_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_DUMMY  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    CLS_ALU   = 2'd0,
    CLS_LOAD  = 2'd1,
    CLS_STORE = 2'd2,
    CLS_JUMP  = 2'd3
  } inst_class_e;

  // Lengths with the DUMMY cycle appended; one fewer without it.
  localparam int LEN_ALU   = 5;
  localparam int LEN_LOAD  = 6;
  localparam int LEN_STORE = 5;
  localparam int LEN_JUMP  = 4;

  // Last state that does real work for a class (before any DUMMY cycle).
  function automatic state_e last_work_state(input inst_class_e cls);
    case (cls)
      CLS_ALU, CLS_LOAD: return ST_WB;
      CLS_STORE:         return ST_MEM;
      default:           return ST_EXEC;
    endcase
  endfunction

  // State in which an instruction of this class completes.
  function automatic state_e exit_state(input inst_class_e cls, input bit insert_dummy);
    return insert_dummy ? ST_DUMMY : last_work_state(cls);
  endfunction

  function automatic int inst_length(input inst_class_e cls, input bit insert_dummy);
    int len;
    case (cls)
      CLS_ALU:   len = LEN_ALU;
      CLS_LOAD:  len = LEN_LOAD;
      CLS_STORE: len = LEN_STORE;
      default:   len = LEN_JUMP;
    endcase
    return insert_dummy ? len : len - 1;
  endfunction

endpackage

// File: rtl/seq_cycle_counter.sv
// seq_cycle_counter
//   Per-instruction cycle counter and retired-instruction counter.
//   Ports:
//     clk, reset      : clock, asynchronous active-low reset
//     advance         : sequencer is moving this cycle (not frozen by stall)
//     clear           : next state is FETCH or IDLE, so the index restarts at 0
//     retire          : an instruction completes this cycle
//     counter         : cycle index within the current instruction
//     retired         : completed-instruction count, wraps naturally
module seq_cycle_counter #(
  parameter int CNT_WIDTH = 3,
  parameter int RET_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 advance,
  input  logic                 clear,
  input  logic                 retire,
  output logic [CNT_WIDTH-1:0] counter,
  output logic [RET_WIDTH-1:0] retired
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [RET_WIDTH-1:0] ret_q, ret_d;

  always_comb begin
    cnt_d = cnt_q;
    if (advance) begin
      cnt_d = clear ? '0 : cnt_q + 1'b1;
    end
    // retire is already gated by stall, so no extra qualification is needed
    ret_d = retire ? ret_q + 1'b1 : ret_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      ret_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ret_q <= ret_d;
    end
  end

  assign counter = cnt_q;
  assign retired = ret_q;

endmodule

// File: rtl/mips_cycle_sequencer.sv
// mips_cycle_sequencer
//   Multi-cycle MIPS control sequencer: FETCH, DECODE, EXEC, optional MEM/WB,
//   optional DUMMY, chosen by the instruction class latched in DECODE.
//   Ports:
//     clk, reset  : clock, asynchronous active-low reset
//     enable      : run request, sampled in IDLE and at instruction end
//     stall       : freezes state, counter and latched class (not in IDLE)
//     inst_class  : 0 ALU, 1 LOAD, 2 STORE, 3 JUMP/BRANCH (sampled in DECODE)
//     state       : current state encoding
//     counter     : cycle index within the instruction
//     flag        : last non-stalled cycle of an instruction
//     instr_done  : flag delayed by one cycle
//     retired     : completed-instruction count
module mips_cycle_sequencer
  import mips_cycle_sequencer_pkg::*;
#(
  parameter int CNT_WIDTH    = 3,
  parameter int RET_WIDTH    = 16,
  parameter int INSERT_DUMMY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 stall,
  input  logic [1:0]           inst_class,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] counter,
  output logic                 flag,
  output logic                 instr_done,
  output logic [RET_WIDTH-1:0] retired
);

  localparam bit DUMMY_ON = (INSERT_DUMMY != 0);

  state_e      state_q, state_d;
  inst_class_e class_q, class_d;
  logic        instr_done_q;
  logic [2:0]  state_raw;
  state_e      exit_target, end_state;
  logic        frozen, flag_int, clear_cnt;

  assign state_raw = state_q;

  // A stall only freezes a running instruction; IDLE keeps sampling enable
  // and an illegal encoding always recovers to IDLE.
  assign frozen = stall && (state_q != ST_IDLE) && (state_raw != 3'd7);

  always_comb begin
    exit_target = enable ? ST_FETCH : ST_IDLE;
    end_state   = DUMMY_ON ? ST_DUMMY : exit_target;
    state_d     = state_q;
    class_d     = class_q;
    case (state_q)
      ST_IDLE:   if (enable) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        class_d = inst_class_e'(inst_class);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        case (class_q)
          CLS_ALU:             state_d = ST_WB;
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          default:             state_d = end_state;
        endcase
      end
      ST_MEM:    state_d = (class_q == CLS_LOAD) ? ST_WB : end_state;
      ST_WB:     state_d = end_state;
      ST_DUMMY:  state_d = exit_target;
      default:   state_d = ST_IDLE;
    endcase
    if (frozen) begin
      state_d = state_q;
      class_d = class_q;
    end
  end

  // Exit state is never IDLE/FETCH/DECODE, so a stale class cannot raise flag
  // before the new class has been latched.
  assign flag_int  = (state_q == exit_state(class_q, DUMMY_ON)) && !stall;
  assign clear_cnt = (state_d == ST_FETCH) || (state_d == ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      class_q      <= CLS_ALU;
      instr_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      class_q      <= class_d;
      instr_done_q <= flag_int;
    end
  end

  seq_cycle_counter #(
    .CNT_WIDTH(CNT_WIDTH),
    .RET_WIDTH(RET_WIDTH)
  ) u_counter (
    .clk     (clk),
    .reset   (reset),
    .advance (!frozen),
    .clear   (clear_cnt),
    .retire  (flag_int),
    .counter (counter),
    .retired (retired)
  );

  assign state      = state_q;
  assign flag       = flag_int;
  assign instr_done = instr_done_q;

endmodule

// File: tb/tb_mips_cycle_sequencer.sv
// tb_mips_cycle_sequencer
//   Directed per-cycle vectors. The stimulus process applies inputs just after
//   each rising edge and queues the outputs expected for that cycle; a monitor
//   pops and compares on the falling edge. dut0 uses default parameters,
//   dut1 uses RET_WIDTH=2 and INSERT_DUMMY=0.
module tb_mips_cycle_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       stall = 1'b0;
  logic [1:0] inst_class = 2'd0;

  logic [2:0]  state0, state1;
  logic [2:0]  counter0, counter1;
  logic        flag0, flag1, done0, done1;
  logic [15:0] retired0;
  logic [1:0]  retired1;

  always #5 clk = ~clk;

  mips_cycle_sequencer dut0 (
    .clk(clk), .reset(reset), .enable(enable), .stall(stall), .inst_class(inst_class),
    .state(state0), .counter(counter0), .flag(flag0), .instr_done(done0), .retired(retired0)
  );

  mips_cycle_sequencer #(.CNT_WIDTH(3), .RET_WIDTH(2), .INSERT_DUMMY(0)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .stall(stall), .inst_class(inst_class),
    .state(state1), .counter(counter1), .flag(flag1), .instr_done(done1), .retired(retired1)
  );

  typedef struct {
    int which;
    int st;
    int cnt;
    int fl;
    int dn;
    int ret;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_exp = 0;

  // Apply inputs for one cycle and queue the outputs expected in that cycle.
  task automatic step(input int which, input logic rst, input logic en, input logic stl,
                      input logic [1:0] cls, input int st, input int cnt, input int fl,
                      input int dn, input int ret);
    exp_t e;
    @(posedge clk);
    #1;
    reset      = rst;
    enable     = en;
    stall      = stl;
    inst_class = cls;
    e.which = which; e.st = st; e.cnt = cnt; e.fl = fl; e.dn = dn; e.ret = ret;
    sb.push_back(e);
    n_exp++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   a_st, a_cnt, a_fl, a_dn, a_ret;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.which == 0) begin
        a_st = int'(state0); a_cnt = int'(counter0); a_fl = int'(flag0);
        a_dn = int'(done0);  a_ret = int'(retired0);
      end else begin
        a_st = int'(state1); a_cnt = int'(counter1); a_fl = int'(flag1);
        a_dn = int'(done1);  a_ret = int'(retired1);
      end
      n_vec++;
      if (a_st != e.st || a_cnt != e.cnt || a_fl != e.fl || a_dn != e.dn || a_ret != e.ret) begin
        n_bad++;
        $display("FAIL vec%0d dut%0d: got st=%0d cnt=%0d flag=%0d done=%0d ret=%0d, want st=%0d cnt=%0d flag=%0d done=%0d ret=%0d",
                 n_vec, e.which, a_st, a_cnt, a_fl, a_dn, a_ret, e.st, e.cnt, e.fl, e.dn, e.ret);
      end else begin
        $display("vec%0d dut%0d ok st=%0d cnt=%0d flag=%0d done=%0d ret=%0d",
                 n_vec, e.which, a_st, a_cnt, a_fl, a_dn, a_ret);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state, then release with enable=1
    step(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0,  0, 0, 0, 0, 0);
    // ALU: 1,2,3,5,6 ; inst_class noise outside DECODE must be ignored
    step(0, 1, 1, 0, 0,  1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0,  2, 1, 0, 0, 0);
    step(0, 1, 1, 0, 3,  3, 2, 0, 0, 0);
    step(0, 1, 1, 0, 3,  5, 3, 0, 0, 0);
    step(0, 1, 1, 0, 2,  6, 4, 1, 0, 0);
    // LOAD: 1,2,3,4,5,6
    step(0, 1, 1, 0, 2,  1, 0, 0, 1, 1);
    step(0, 1, 1, 0, 1,  2, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0,  3, 2, 0, 0, 1);
    step(0, 1, 1, 0, 3,  4, 3, 0, 0, 1);
    step(0, 1, 1, 0, 2,  5, 4, 0, 0, 1);
    step(0, 1, 1, 0, 0,  6, 5, 1, 0, 1);
    // STORE: 1,2,3,4,6
    step(0, 1, 1, 0, 0,  1, 0, 0, 1, 2);
    step(0, 1, 1, 0, 2,  2, 1, 0, 0, 2);
    step(0, 1, 1, 0, 1,  3, 2, 0, 0, 2);
    step(0, 1, 1, 0, 0,  4, 3, 0, 0, 2);
    step(0, 1, 1, 0, 0,  6, 4, 1, 0, 2);
    // JUMP: 1,2,3,6
    step(0, 1, 1, 0, 0,  1, 0, 0, 1, 3);
    step(0, 1, 1, 0, 3,  2, 1, 0, 0, 3);
    step(0, 1, 1, 0, 1,  3, 2, 0, 0, 3);
    step(0, 1, 1, 0, 0,  6, 3, 1, 0, 3);
    // ALU with 3 stalled cycles in EXEC and 3 in DUMMY
    step(0, 1, 1, 0, 0,  1, 0, 0, 1, 4);
    step(0, 1, 1, 0, 0,  2, 1, 0, 0, 4);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0,  3, 2, 0, 0, 4);
    step(0, 1, 1, 0, 0,  3, 2, 0, 0, 4);
    step(0, 1, 1, 0, 0,  5, 3, 0, 0, 4);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0,  6, 4, 0, 0, 4);
    step(0, 1, 1, 0, 0,  6, 4, 1, 0, 4);
    // enable dropped in DECODE: instruction completes, then IDLE
    step(0, 1, 1, 0, 0,  1, 0, 0, 1, 5);
    step(0, 1, 0, 0, 0,  2, 1, 0, 0, 5);
    step(0, 1, 0, 0, 0,  3, 2, 0, 0, 5);
    step(0, 1, 0, 0, 0,  5, 3, 0, 0, 5);
    step(0, 1, 0, 0, 0,  6, 4, 1, 0, 5);
    step(0, 1, 0, 0, 0,  0, 0, 0, 1, 6);
    step(0, 1, 0, 1, 0,  0, 0, 0, 0, 6);
    // stall has no effect in IDLE: enable still starts FETCH
    step(0, 1, 1, 1, 1,  0, 0, 0, 0, 6);
    // LOAD, reset pulled low just after entering MEM
    step(0, 1, 1, 0, 1,  1, 0, 0, 0, 6);
    step(0, 1, 1, 0, 1,  2, 1, 0, 0, 6);
    step(0, 1, 1, 0, 0,  3, 2, 0, 0, 6);
    step(0, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0,  0, 0, 0, 0, 0);

    // dut1: five back-to-back ALU instructions, 4 cycles each, 2-bit retired
    step(1, 1, 1, 0, 0,  0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 1, 0, 0,  1, 0, 0, (i > 0) ? 1 : 0, i % 4);
      step(1, 1, 1, 0, 0,  2, 1, 0, 0, i % 4);
      step(1, 1, 1, 0, 0,  3, 2, 0, 0, i % 4);
      step(1, 1, (i < 4) ? 1'b1 : 1'b0, 0, 0,  5, 3, 1, 0, i % 4);
    end
    step(1, 1, 0, 0, 0,  0, 0, 0, 1, 1);

    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
        n_bad++;
        $display("FAIL scoreboard: %0d expected vectors never compared", sb.size());
    end
    if (n_vec != n_exp) begin
        n_bad++;
        $display("FAIL count: %0d vectors compared, %0d queued", n_vec, n_exp);
    end
    if (n_bad != 0) begin
        $display("FAIL == %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    end else begin
        $display("PASS == %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    end
    $finish;
  end

endmodule
